// File: rtl/instr_queue_pkg.sv
// rtl/instr_queue_pkg.sv - shared processor constants used by fetch_unit and instr_queue
package instr_queue_pkg;

  localparam int XLEN     = 32;
  localparam int PC_INC   = 4;
  localparam int IQ_DEPTH = 8;

  // decode may request 3, which behaves as a request for 2
  function automatic logic [1:0] clamp_deq(input logic [1:0] req);
    return (req == 2'd3) ? 2'd2 : req;
  endfunction

endpackage

// File: rtl/iq_storage_ram.sv
// rtl/iq_storage_ram.sv - instruction queue entry array, two write ports and two async read ports
module iq_storage_ram
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int EW    = 2 * XLEN,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr0,
  input  logic [EW-1:0] wdata0,
  input  logic [AW-1:0] waddr1,
  input  logic [EW-1:0] wdata1,
  input  logic [AW-1:0] raddr0,
  output logic [EW-1:0] rdata0,
  input  logic [AW-1:0] raddr1,
  output logic [EW-1:0] rdata1
);

  logic [EW-1:0] mem [DEPTH];

  // contents are deliberately unreset; pointers alone define validity
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr0] <= wdata0;
      mem[waddr1] <= wdata1;
    end
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];

endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - circular instruction queue between fetch_unit (pairs in) and decode (0-2 out)
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] instr1,
  input  logic [WIDTH-1:0] instr2,
  input  logic [WIDTH-1:0] in_pc,
  input  logic             in_valid,
  input  logic             is_branch_taken,
  input  logic [1:0]       deq_req,
  output logic             stall,
  output logic [WIDTH-1:0] out_instr1,
  output logic [WIDTH-1:0] out_instr2,
  output logic [WIDTH-1:0] out_pc1,
  output logic [WIDTH-1:0] out_pc2,
  output logic             out_valid1,
  output logic             out_valid2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      wr_ptr;
  logic [CW-1:0]      count;
  logic               enq;
  logic [1:0]         deq_c;
  logic [CW-1:0]      deq_n;
  logic [CW-1:0]      enq_n;
  logic [2*WIDTH-1:0] rdata0;
  logic [2*WIDTH-1:0] rdata1;

  // a pair needs two free slots, so stall once fewer than two remain
  assign stall = count > CW'(DEPTH - 2);
  assign enq   = in_valid & ~stall & ~is_branch_taken;
  assign deq_c = clamp_deq(deq_req);
  assign deq_n = (CW'(deq_c) > count) ? count : CW'(deq_c);
  assign enq_n = enq ? CW'(2) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (is_branch_taken) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + PW'(2);
      end
      rd_ptr <= rd_ptr + PW'(deq_n);
      count  <= count + enq_n - deq_n;
    end
  end

  iq_storage_ram #(
    .DEPTH (DEPTH),
    .EW    (2 * WIDTH),
    .AW    (PW)
  ) u_ram (
    .clk    (clk),
    .we     (enq),
    .waddr0 (wr_ptr),
    .wdata0 ({instr1, in_pc}),
    .waddr1 (wr_ptr + PW'(1)),
    .wdata1 ({instr2, in_pc + WIDTH'(PC_INC)}),
    .raddr0 (rd_ptr),
    .rdata0 (rdata0),
    .raddr1 (rd_ptr + PW'(1)),
    .rdata1 (rdata1)
  );

  assign out_valid1 = count != '0;
  assign out_valid2 = count >= CW'(2);

  assign out_instr1 = out_valid1 ? rdata0[2*WIDTH-1:WIDTH] : '0;
  assign out_pc1    = out_valid1 ? rdata0[WIDTH-1:0]       : '0;
  assign out_instr2 = out_valid2 ? rdata1[2*WIDTH-1:WIDTH] : '0;
  assign out_pc2    = out_valid2 ? rdata1[WIDTH-1:0]       : '0;

endmodule

// File: tb/tb_instr_queue.sv
// tb/tb_instr_queue.sv - scoreboard bench for instr_queue
module tb_instr_queue;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] instr1, instr2, in_pc;
  logic             in_valid, is_branch_taken;
  logic [1:0]       deq_req;
  logic             stall;
  logic [WIDTH-1:0] out_instr1, out_instr2, out_pc1, out_pc2;
  logic             out_valid1, out_valid2;

  logic [63:0] sb_q[$];
  int          tests  = 0;
  int          errors = 0;

  instr_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .instr1          (instr1),
    .instr2          (instr2),
    .in_pc           (in_pc),
    .in_valid        (in_valid),
    .is_branch_taken (is_branch_taken),
    .deq_req         (deq_req),
    .stall           (stall),
    .out_instr1      (out_instr1),
    .out_instr2      (out_instr2),
    .out_pc1         (out_pc1),
    .out_pc2         (out_pc2),
    .out_valid1      (out_valid1),
    .out_valid2      (out_valid2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_stall"}, 64'(stall), 64'd0);
    check({tag, "_v1"}, 64'(out_valid1), 64'd0);
    check({tag, "_v2"}, 64'(out_valid2), 64'd0);
    check({tag, "_e1"}, {out_instr1, out_pc1}, 64'd0);
    check({tag, "_e2"}, {out_instr2, out_pc2}, 64'd0);
  endtask

  // called just after a falling edge; compares current outputs, then advances the model and the DUT
  task automatic cycle(input logic v, input logic [31:0] i1, input logic [31:0] i2,
                       input logic [31:0] pc, input logic [1:0] d, input logic f);
    int          sz;
    int          n;
    logic [63:0] tmp;
    in_valid = v; instr1 = i1; instr2 = i2; in_pc = pc; deq_req = d; is_branch_taken = f;
    #1;
    sz = sb_q.size();
    check("stall", 64'(stall), 64'(sz > DEPTH - 2));
    check("count", 64'(dut.count), 64'(sz));
    check("valid1", 64'(out_valid1), 64'(sz >= 1));
    check("valid2", 64'(out_valid2), 64'(sz >= 2));
    check("entry1", {out_instr1, out_pc1}, (sz >= 1) ? sb_q[0] : 64'd0);
    check("entry2", {out_instr2, out_pc2}, (sz >= 2) ? sb_q[1] : 64'd0);
    if (f) begin
      sb_q.delete();
    end else begin
      n = (d == 2'd3) ? 2 : int'(d);
      if (n > sz) n = sz;
      repeat (n) tmp = sb_q.pop_front();
      if (v && !(sz > DEPTH - 2)) begin
        sb_q.push_back({i1, pc});
        sb_q.push_back({i2, pc + 32'd4});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int k);
    repeat (k) cycle(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; is_branch_taken = 1'b0; deq_req = 2'd0;
    instr1 = '0; instr2 = '0; in_pc = '0;
    @(posedge clk); @(negedge clk);
    check_idle_outputs("reset");
    check("reset_count", 64'(dut.count), 64'd0);
    reset = 1'b1;

    // basic flow then fill to capacity; the fifth pair must be dropped
    cycle(1'b1, 32'hAAAA0001, 32'hAAAA0002, 32'h100, 2'd0, 1'b0);
    check("basic_pc1", 64'(out_pc1), 64'h100);
    check("basic_pc2", 64'(out_pc2), 64'h104);
    for (int k = 1; k < 4; k++)
      cycle(1'b1, 32'hAAAA0001 + 32'(2*k), 32'hAAAA0002 + 32'(2*k), 32'h100 + 32'(8*k), 2'd0, 1'b0);
    check("fill_stall", 64'(stall), 64'd1);
    cycle(1'b1, 32'hDEAD0001, 32'hDEAD0002, 32'h900, 2'd0, 1'b0);
    check("fill_head", 64'(out_pc1), 64'h100);

    // full with dequeue: no enqueue, count 8 -> 6, stall falls
    cycle(1'b1, 32'hDEAD0003, 32'hDEAD0004, 32'h980, 2'd2, 1'b0);
    check("simul_stall", 64'(stall), 64'd0);
    check("simul_count", 64'(dut.count), 64'd6);

    // flush beats simultaneous enqueue and dequeue
    cycle(1'b1, 32'hBEEF0001, 32'hBEEF0002, 32'hA00, 2'd2, 1'b1);
    check_idle_outputs("flush");

    // wrap-around: six pairs, dequeue two per cycle after the first
    for (int k = 0; k < 6; k++)
      cycle(1'b1, 32'hC0DE0000 + 32'(2*k), 32'hC0DE0001 + 32'(2*k), 32'h2000 + 32'(8*k),
            (k == 0) ? 2'd0 : 2'd2, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 2'd3, 1'b0);
    idle(1);

    // PC addition wraps modulo 2^32, and single dequeues leave odd counts
    cycle(1'b1, 32'h11111111, 32'h22222222, 32'hFFFFFFFC, 2'd1, 1'b0);
    check("pcwrap", 64'(out_pc2), 64'h0);
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0);

    for (int k = 0; k < 300; k++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom & 32'hFFFF_FFFC,
            2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));

    // asynchronous reset between edges with four entries held
    cycle(1'b0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b1);
    cycle(1'b1, 32'h5000, 32'h5001, 32'h500, 2'd0, 1'b0);
    cycle(1'b1, 32'h5002, 32'h5003, 32'h508, 2'd0, 1'b0);
    check("pre_areset_count", 64'(dut.count), 64'd4);
    #2 reset = 1'b0;
    #1;
    check_idle_outputs("areset");
    check("areset_count", 64'(dut.count), 64'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 32'h6000, 32'h6001, 32'h600, 2'd0, 1'b0);
    check("resume_pc1", 64'(out_pc1), 64'h600);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
